holly_bus_router: RTL
=====================

# holly_bus_router

Parametrised SH4 data-side bus router for the HOLLY address map. It takes one core data request, decodes the address into one of `NUM_TGT` inclusive address windows or a default target, and forwards the request to that target. It then waits for that target's response and returns it to the core as a registered response. It replaces the fixed chip-select compare chain and two-way read mux at the top level, and adds an optional timeout for targets that never answer.

## Interface
**Parameters**
- `ADDR_W`, 29: decoded address width; `req_addr[ADDR_W-1:0]` is compared, so P-region bits are ignored.
- `DATA_W`, 64: data width.
- `NUM_TGT`, 4: number of windowed targets. Range 1..16.
- `TGT_BASE`, 0: flattened `NUM_TGT*ADDR_W` vector; window i occupies bits `[i*ADDR_W +: ADDR_W]`.
- `TGT_LIMIT`, 0: flattened `NUM_TGT*ADDR_W` vector of inclusive window upper bounds.
- `TIMEOUT`, 255: wait-cycle limit. Range 1..65535.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_addr` in 32: core request address.
- `req_wdata` in DATA_W: core write data.
- `req_wmask` in DATA_W/8: core byte write mask.
- `req_wen` in 1: 1 = write, 0 = read.
- `req_valid` in 1: core request; held high until `resp_valid`.
- `resp_rdata` out DATA_W: registered read data.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_err` out 1: the response was produced by a timeout; valid with `resp_valid`.
- `t_req_addr` out ADDR_W: latched address, shared by all targets.
- `t_req_wdata` out DATA_W: latched write data, shared by all targets.
- `t_req_wmask` out DATA_W/8: latched byte mask, shared by all targets.
- `t_req_wen` out 1: latched write enable, shared by all targets.
- `t_req_valid` out NUM_TGT+1: one-hot target select; bit NUM_TGT is the default target.
- `t_resp_rdata` in (NUM_TGT+1)*DATA_W: per-target read data, flattened.
- `t_resp_valid` in NUM_TGT+1: per-target one-cycle response pulse.
- `err_count` out 16: saturating count of timeouts.

## Operation
**States**
- `IDLE`
  - On `req_valid`, latch address, write data, mask and `req_wen`, then go to `WAIT`.
  - Decode: target i matches when `TGT_BASE[i] <= addr <= TGT_LIMIT[i]`. If several windows match, the lowest index wins.
  - No match selects the default target (index NUM_TGT).
- `WAIT`
  - Hold the selected `t_req_valid` bit.
  - When `t_resp_valid[sel]` is sampled high:
    - register the response data into `resp_rdata`; force it to 0 for writes;
    - clear `t_req_valid`;
    - go to `RESP`.
- `RESP`
  - Drive `resp_valid=1` for one cycle, then return to `IDLE`.
  - A new request is accepted on the `IDLE` cycle that follows.

**Ignored inputs**
- `t_resp_valid` from a non-selected target.
- `t_resp_valid` in `IDLE` or `RESP`.

**Reset values**
- State `IDLE`.
- `t_req_valid=0`, `resp_valid=0`, `resp_err=0`.
- `resp_rdata=0`, `err_count=0`.
- `t_req_*` latches = 0.

**Reset mid-transaction**
- Reset returns to `IDLE` at the next edge and drops `t_req_valid`.
- A late target response is ignored.
- No `resp_valid` is generated for the aborted request.

## Timing
- Request side:
  - `req_valid` sampled high at edge N → `t_req_valid` and `t_req_*` valid after edge N.
  - Decode is combinational on the `req_addr` inputs and registered at edge N.
- Response side:
  - `t_resp_valid` sampled high at edge M → `resp_valid` high for the cycle after edge M.
  - `t_req_valid` drops at that same edge M.
- Minimum latency: `req_valid` to `resp_valid` is 2 cycles, achieved when the target responds in the first `WAIT` cycle.
- Back-to-back throughput: one transaction per 3 cycles minimum.
- Timeout counter (16-bit):
  - cleared on entry to `WAIT`;
  - increments each `WAIT` cycle without a response.
- Timeout firing:
  - fires when the count equals `TIMEOUT-1` and no response is present;
  - that edge goes to `RESP` with `resp_rdata` all ones, `resp_err=1`, `err_count+1` (saturating at 16'hFFFF).
- If a response and the timeout condition occur on the same edge, the response wins and `resp_err=0`.

## Configuration
- Macro: `BUS_ROUTER_TIMEOUT_EN`.
- Defined:
  - the timeout counter, `resp_err` and `err_count` behave as described above.
- Undefined:
  - no counter is built and `WAIT` waits indefinitely;
  - `resp_err` and `err_count` are tied to 0;
  - the `TIMEOUT` parameter is ignored.

## Test plan
- **Windowed read:** `NUM_TGT=4`, window 2 = 0x005F7C00..0x005F7CFF, `req_addr=0xA05F7C44` read; target 2 answers in the first `WAIT` cycle with 0x1122334455667788.
  - `t_req_valid=5'b00100`, `t_req_addr=0x005F7C44`.
  - `resp_rdata=0x1122334455667788` exactly 2 cycles after the request; `resp_err=0`.
- **Unmapped write:** `req_addr=0x0C000010`, `wmask=0x0F`, `wdata=0xCAFE`.
  - `t_req_valid=5'b10000`, `t_req_wmask=0x0F`, `t_req_wen=1`.
  - Response has `resp_rdata=0`.
- **Overlap and stray response:** windows 0 and 1 both cover 0x00700000; target 1 pulses `t_resp_valid` during `WAIT`.
  - Target 0 is selected; target 1's pulse is ignored.
  - Completion occurs only on target 0's pulse.
- **Timeout:** macro defined, `TIMEOUT=8`, target never answers.
  - `resp_valid` on cycle 10 with `resp_rdata=64'hFFFF_FFFF_FFFF_FFFF`, `resp_err=1`, `err_count=1`.
  - Response arriving on the same edge as the timeout → `resp_err=0`.
- **Reset in WAIT:** assert `rst` for one cycle while in `WAIT`; the target answers 1 cycle later.
  - `t_req_valid=0` after the reset edge; no `resp_valid` is generated.
  - A following request completes normally.
- **Macro undefined:** target silent for 1000 cycles, then answers.
  - Router stays in `WAIT` throughout and completes on the answer.
  - `resp_err=0`, `err_count=0`.

Source files
------------

// File: rtl/holly_bus_router.sv
// HOLLY data-side bus router: decodes one core request into NUM_TGT windows or a default target
// and returns a registered response. Optional per-request timeout under BUS_ROUTER_TIMEOUT_EN.
module holly_bus_router #(
  parameter int unsigned                 ADDR_W    = 29,
  parameter int unsigned                 DATA_W    = 64,
  parameter int unsigned                 NUM_TGT   = 4,
  parameter logic [NUM_TGT*ADDR_W-1:0]   TGT_BASE  = '0,
  parameter logic [NUM_TGT*ADDR_W-1:0]   TGT_LIMIT = '0,
  parameter int unsigned                 TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [DATA_W/8-1:0]           req_wmask,
  input  logic                          req_wen,
  input  logic                          req_valid,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic                          resp_valid,
  output logic                          resp_err,
  output logic [ADDR_W-1:0]             t_req_addr,
  output logic [DATA_W-1:0]             t_req_wdata,
  output logic [DATA_W/8-1:0]           t_req_wmask,
  output logic                          t_req_wen,
  output logic [NUM_TGT:0]              t_req_valid,
  input  logic [(NUM_TGT+1)*DATA_W-1:0] t_resp_rdata,
  input  logic [NUM_TGT:0]              t_resp_valid,
  output logic [15:0]                   err_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wmask;
  logic                  r_wen;
  logic [NUM_TGT:0]      r_t_req_valid;
  logic [DATA_W-1:0]     r_rdata;
  logic [ADDR_W-1:0]     w_addr;
  logic [NUM_TGT:0]      w_sel;
  logic                  w_hit;
  logic [DATA_W-1:0]     w_rdata;
  logic                  w_resp_hit;
  logic                  w_timeout;
  logic                  w_resp_valid;
  logic                  w_unused_addr;

  assign w_addr        = req_addr[ADDR_W-1:0];
  assign w_unused_addr = ^req_addr[31:ADDR_W];

  // First matching window wins; anything unmatched goes to the default target.
  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_TGT; i++) begin
      if (!w_hit && (w_addr >= TGT_BASE[i*ADDR_W +: ADDR_W]) &&
          (w_addr <= TGT_LIMIT[i*ADDR_W +: ADDR_W])) begin
        w_sel[i] = 1'b1;
        w_hit    = 1'b1;
      end
    end
    if (!w_hit) w_sel[NUM_TGT] = 1'b1;
  end

  // t_req_valid is one-hot, so it doubles as the response mux select.
  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i <= NUM_TGT; i++) begin
      if (r_t_req_valid[i]) w_rdata = w_rdata | t_resp_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign w_resp_hit = (r_state == ST_WAIT) && (|(t_resp_valid & r_t_req_valid));

`ifdef BUS_ROUTER_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_err;
  logic [15:0] r_err_count;

  assign w_timeout = (r_state == ST_WAIT) && !w_resp_hit && (r_to_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt    <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (r_state == ST_IDLE) r_to_cnt <= '0;
      else if ((r_state == ST_WAIT) && !w_resp_hit) r_to_cnt <= r_to_cnt + 16'd1;

      if (w_resp_hit) r_err <= 1'b0;
      else if (w_timeout) begin
        r_err <= 1'b1;
        if (r_err_count != '1) r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign resp_err  = r_err;
  assign err_count = r_err_count;
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
  assign err_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_next_state = ST_WAIT;
      ST_WAIT: if (w_resp_hit || w_timeout) w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_resp_valid = (r_state == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wmask       <= '0;
      r_wen         <= 1'b0;
      r_t_req_valid <= '0;
      r_rdata       <= '0;
    end else begin
      if ((r_state == ST_IDLE) && req_valid) begin
        r_addr        <= w_addr;
        r_wdata       <= req_wdata;
        r_wmask       <= req_wmask;
        r_wen         <= req_wen;
        r_t_req_valid <= w_sel;
      end
      if (w_resp_hit) begin
        r_rdata       <= r_wen ? '0 : w_rdata;
        r_t_req_valid <= '0;
      end else if (w_timeout) begin
        r_rdata       <= '1;
        r_t_req_valid <= '0;
      end
    end
  end

  assign resp_rdata  = r_rdata;
  assign resp_valid  = w_resp_valid;
  assign t_req_addr  = r_addr;
  assign t_req_wdata = r_wdata;
  assign t_req_wmask = r_wmask;
  assign t_req_wen   = r_wen;
  assign t_req_valid = r_t_req_valid;

endmodule
